// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer and its reference checkers.
//   - MODE_* : reference-function codes (6 and 7 are reserved and expect 0)
//   - state_e: sequencer FSM encoding
//   - gate_expected(): expected gate output for an input vector and mode
package gate_test_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  // Widest gate the reference function understands.
  localparam int MAX_IN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Only the low n_in bits of vec take part; the rest are masked off so a
  // narrow vector zero-extended to MAX_IN gives the right AND/NAND result.
  function automatic logic gate_expected(input logic [MAX_IN-1:0] vec,
                                         input int                n_in,
                                         input logic [2:0]        mode);
    logic [MAX_IN-1:0] mask;
    logic              all_one;
    logic              any_one;
    logic              parity;
    logic              res;
    mask = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      mask[i] = (i < n_in);
    end
    all_one = &(vec | ~mask);
    any_one = |(vec & mask);
    parity  = ^(vec & mask);
    case (mode)
      MODE_AND:  res = all_one;
      MODE_OR:   res = any_one;
      MODE_NAND: res = ~all_one;
      MODE_NOR:  res = ~any_one;
      MODE_XOR:  res = parity;
      MODE_XNOR: res = ~parity;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for an N_IN-input gate.
// Ports:
//   vec  in  N_IN  gate input vector (bit 0 = input i1)
//   mode in  3     reference function code (see gate_test_pkg)
//   exp  out 1     expected gate output
module gate_ref_model
  import gate_test_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      mode,
  output logic            exp
);

  assign exp = gate_expected(MAX_IN'(vec), N_IN, mode);

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus sequencer with on-chip compare for an N_IN-input gate.
// Walks every input vector, holds each for HOLD_CYCLES clocks, samples the
// gate output on the last hold cycle and counts mismatches against the
// reference function latched at start.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start, mode   run request (accepted in IDLE/DONE) and reference function
//   stim          vector driven to the gate (bit 0 = i1)
//   dut_o         gate output under test
//   busy, done    run in progress / one-cycle completion pulse
//   pass, err_cnt last run clean / saturating mismatch count
// Optional build macro GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN adds
//   fail_vec, fail_valid: first mismatching vector of the run.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
  ,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_valid
`endif
);

  localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  // One spare bit so the last-vector compare can never alias vector 0.
  localparam logic [N_IN:0]   VEC_LAST  = {1'b0, {N_IN{1'b1}}};

  state_e           state_q, state_d;
  logic [N_IN:0]    vec_q, vec_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
  logic [N_IN-1:0]  fvec_q, fvec_d;
  logic             fvld_q, fvld_d;
`endif

  logic exp_bit;
  logic sample;
  logic mismatch;

  gate_ref_model #(
    .N_IN (N_IN)
  ) u_ref (
    .vec  (vec_q[N_IN-1:0]),
    .mode (mode_q),
    .exp  (exp_bit)
  );

  // Compare on the last hold cycle: registered stim vs. live gate output.
  assign sample   = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);
  assign mismatch = sample && (dut_o != exp_bit);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
    fvec_d  = fvec_q;
    fvld_d  = fvld_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          mode_d  = mode;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
          fvec_d  = '0;
          fvld_d  = 1'b0;
`endif
        end
      end
      ST_APPLY: begin
        if (mismatch && !(&err_q)) begin
          err_d = err_q + 1'b1;
        end
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
        if (mismatch && !fvld_q) begin
          fvec_d = vec_q[N_IN-1:0];
          fvld_d = 1'b1;
        end
`endif
        if (sample) begin
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
      fvec_q  <= '0;
      fvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
      fvec_q  <= fvec_d;
      fvld_q  <= fvld_d;
`endif
    end
  end

  assign stim    = vec_q[N_IN-1:0];
  assign busy    = (state_q == ST_APPLY);
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
  assign fail_vec   = fvec_q;
  assign fail_valid = fvld_q;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer. Two instances: A (N_IN=2, HOLD=4, ERR_W=8)
// and B (N_IN=3, HOLD=1, ERR_W=2). Each drives a modelled gate whose output
// can be a chosen function, stuck value, and per-vector injected flips.
`timescale 1ns/1ps
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [2:0] mode_a, mode_b;
  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       dut_a, dut_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  int         kind_a, kind_b;
  logic [7:0] flip_a, flip_b;
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
  logic [1:0] fv_a;
  logic [2:0] fv_b;
  logic       fval_a, fval_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: expected output from the count of ones in the vector.
  function automatic logic tb_ref(input int md, input int v, input int n);
    int pc;
    pc = $countones(v);
    case (md)
      0: return pc == n;
      1: return pc != 0;
      2: return pc != n;
      3: return pc == 0;
      4: return (pc % 2) == 1;
      5: return (pc % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Modelled gate: kinds 0..5 behave like the matching function, 6/7 stuck.
  function automatic logic tb_gate(input int kind, input int v, input int n);
    if (kind < 6) return tb_ref(kind, v, n);
    return kind == 7;
  endfunction

  assign dut_a = tb_gate(kind_a, int'(stim_a), 2) ^ flip_a[stim_a];
  assign dut_b = tb_gate(kind_b, int'(stim_b), 3) ^ flip_b[stim_b];

  gate_test_sequencer #(.N_IN(2), .HOLD_CYCLES(4), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .stim(stim_a),
    .dut_o(dut_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a)
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
    , .fail_vec(fv_a), .fail_valid(fval_a)
`endif
  );

  gate_test_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .stim(stim_b),
    .dut_o(dut_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
    , .fail_vec(fv_b), .fail_valid(fval_b)
`endif
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_stim(input int sel); return sel ? int'(stim_b) : int'(stim_a); endfunction
  function automatic int get_busy(input int sel); return sel ? int'(busy_b) : int'(busy_a); endfunction
  function automatic int get_done(input int sel); return sel ? int'(done_b) : int'(done_a); endfunction
  function automatic int get_pass(input int sel); return sel ? int'(pass_b) : int'(pass_a); endfunction
  function automatic int get_err(input int sel);  return sel ? int'(err_b)  : int'(err_a);  endfunction
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
  function automatic int get_fv(input int sel);   return sel ? int'(fv_b)   : int'(fv_a);   endfunction
  function automatic int get_fval(input int sel); return sel ? int'(fval_b) : int'(fval_a); endfunction
`endif

  task automatic drive(input int sel, input logic s, input int md);
    if (sel != 0) begin start_b = s; mode_b = 3'(md); end
    else          begin start_a = s; mode_a = 3'(md); end
  endtask

  // One complete run from an idle/done sequencer, checked against the model.
  task automatic run(input int sel, input int md, input int kind,
                     input logic [7:0] fl, input bit perturb, input string tag);
    int n, h, lat, k, bad, raw, err_exp, first, emax;
    n    = (sel != 0) ? 3 : 2;
    h    = (sel != 0) ? 1 : 4;
    emax = (sel != 0) ? 3 : 255;
    lat  = (1 << n) * h;   // posedges after the start edge until done is seen
    raw = 0;
    first = -1;
    for (int v = 0; v < (1 << n); v++) begin
      if ((tb_gate(kind, v, n) ^ fl[v]) != tb_ref(md, v, n)) begin
        raw++;
        if (first < 0) first = v;
      end
    end
    err_exp = (raw > emax) ? emax : raw;
    if (sel != 0) begin kind_b = kind; flip_b = fl; end
    else          begin kind_a = kind; flip_a = fl; end
    @(negedge clk); drive(sel, 1'b1, md);
    @(negedge clk); drive(sel, 1'b0, md);
    check_eq({tag, "_busy_start"}, get_busy(sel), 1);
    check_eq({tag, "_err_start"}, get_err(sel), 0);
    k = 0;
    bad = 0;
    while (get_done(sel) == 0 && k < lat + 20) begin
      if (get_stim(sel) != k / h || get_busy(sel) != 1) bad++;
      if (perturb && k == 4) drive(sel, 1'b1, (md + 3) % 8);
      if (perturb && k == 5) drive(sel, 1'b0, (md + 5) % 8);
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, k, lat);
    check_eq({tag, "_walk_bad"}, bad, 0);
    check_eq({tag, "_done"}, get_done(sel), 1);
    check_eq({tag, "_busy_end"}, get_busy(sel), 0);
    check_eq({tag, "_err"}, get_err(sel), err_exp);
    check_eq({tag, "_pass"}, get_pass(sel), (raw == 0) ? 1 : 0);
    check_eq({tag, "_stim_last"}, get_stim(sel), (1 << n) - 1);
`ifdef GATE_TEST_SEQUENCER_FAIL_CAPTURE_EN
    check_eq({tag, "_fail_valid"}, get_fval(sel), (raw != 0) ? 1 : 0);
    check_eq({tag, "_fail_vec"}, get_fv(sel), (first < 0) ? 0 : first);
`endif
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, get_done(sel), 0);
    check_eq({tag, "_pass_hold"}, get_pass(sel), (raw == 0) ? 1 : 0);
  endtask

  initial begin
    int dcount;
    rst_n = 1'b1;
    start_a = 1'b0; start_b = 1'b0; mode_a = '0; mode_b = '0;
    kind_a = 0; kind_b = 0; flip_a = '0; flip_b = '0;
    #1 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_stim", get_stim(s), 0);
      check_eq("rst_busy", get_busy(s), 0);
      check_eq("rst_done", get_done(s), 0);
      check_eq("rst_pass", get_pass(s), 0);
      check_eq("rst_err",  get_err(s), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(0, 0, 0, 8'h00, 1'b0, "and2_ok");
    run(0, 0, 1, 8'h00, 1'b0, "and2_vs_or2");
    run(1, 4, 4, 8'h00, 1'b0, "xor3_ok");
    run(1, 4, 4, 8'hFF, 1'b0, "xor3_inv_sat");
    run(1, 1, 6, 8'h00, 1'b0, "or3_stuck0_sat");
    run(0, 2, 2, 8'h04, 1'b1, "nand2_perturb");
    run(1, 5, 5, 8'h00, 1'b1, "xnor3_perturb");
    run(0, 6, 6, 8'h00, 1'b0, "reserved_ok");

    // Asynchronous reset in the middle of a run on A.
    kind_a = 0; flip_a = 8'h01;
    @(negedge clk); drive(0, 1'b1, 0);
    @(negedge clk); drive(0, 1'b0, 0);
    repeat (6) @(negedge clk);
    check_eq("midrst_pre_err", get_err(0), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_stim", get_stim(0), 0);
    check_eq("midrst_busy", get_busy(0), 0);
    check_eq("midrst_err",  get_err(0), 0);
    #9 rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    check_eq("midrst_no_done", dcount, 0);
    check_eq("midrst_idle_busy", get_busy(0), 0);
    run(0, 3, 3, 8'h00, 1'b0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      int sel, md, kind;
      logic [7:0] fl;
      sel  = $urandom_range(0, 1);
      md   = $urandom_range(0, 7);
      kind = $urandom_range(0, 7);
      fl   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      run(sel, md, kind, fl, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
